// File: rtl/alu_mul_sequencer_pkg.sv
// Shared encodings for the ALU-sharing multiply sequencer.
//   OP_*        : Alu_Op codes understood by the shared CLA ALU
//   mul_state_e : sequencer FSM states (IDLE, RUN, DONE)
package alu_mul_sequencer_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that
// borrows the shared datapath ALU for every partial-product add.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 request, sampled only in IDLE
//   multiplicand/multiplier operands captured on the accept edge
//   busy                  high in RUN and DONE
//   done                  one-cycle pulse, product is final
//   product               accumulator; final from DONE until the next accept
//   alu_req               ALU ownership request (high in RUN)
//   alu_a, alu_b, alu_op  ALU operands/op; operands are 0 outside RUN
//   alu_result, alu_cout  combinational sum/carry returned by the ALU
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter logic [2:0]  ALU_OP_ADD = OP_ADD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 alu_req,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e           state;
  logic [WIDTH-1:0]     mcand_r;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;

  // alu_req is a registered copy of (state == S_RUN), so it doubles as the
  // RUN qualifier for the operand lines without any decode of state.
  assign alu_a   = alu_req ? acc[2*WIDTH-1:WIDTH] : '0;
  assign alu_b   = (alu_req && acc[0]) ? mcand_r : '0;
  assign alu_op  = ALU_OP_ADD;
  assign product = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
      mcand_r <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_r <= multiplicand;
            acc     <= {{WIDTH{1'b0}}, multiplier};
            count   <= '0;
            state   <= S_RUN;
            busy    <= 1'b1;
            alu_req <= 1'b1;
          end
        end
        S_RUN: begin
          // Carry-extended sum replaces the high half, then the whole
          // accumulator shifts right one place.
          acc <= {alu_cout, alu_result, acc[WIDTH-1:1]};
          if (count == LAST) begin
            state   <= S_DONE;
            alu_req <= 1'b0;
            done    <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          alu_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
